word_packer: RTL and testbench
==============================

# word_packer

Narrow-to-wide bit-stream gearbox in front of the LDPC encoder. It accepts IN_WIDTH-bit words from the host-side bus and packs them, MSB-first and without gaps, into OUT_WIDTH-bit information blocks for the encoder core. Bits left over from a word that completes a block carry over into the next block. A frame marker zero-pads the final partial block so frames stay block-aligned. It is the inverse of the codeword unpacker on the encoder output side.

## Interface
- IN_WIDTH, 32, input word width; must be less than OUT_WIDTH
- OUT_WIDTH, 648, output block width; need not be a multiple of IN_WIDTH
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- valid_in  in  1  input word valid
- data_in  in  IN_WIDTH  input word; bit IN_WIDTH-1 is the earliest bit
- last_in  in  1  qualifies the accepted word as the final word of a frame
- ready_in  out  1  word accepted when valid_in && ready_in
- valid_out  out  1  output block valid
- data_out  out  OUT_WIDTH  packed block; bit OUT_WIDTH-1 is the earliest bit
- last_out  out  1  block is the final (possibly padded) block of a frame
- ready_out  in  1  block consumed when valid_out && ready_out
- blk_cnt  out  16  emitted-block counter; present only with WORD_PACKER_STATS_EN

## Operation
- State:
  - accumulator acc: OUT_WIDTH+IN_WIDTH bits, MSB-aligned
  - fill counter: $clog2(OUT_WIDTH+IN_WIDTH+1) bits
  - output register: data_out, valid_out, last_out
  - FSM with states FILL and FLUSH
- FILL, word accepted, s = fill + IN_WIDTH:
  - s < OUT_WIDTH, no last_in: append the word below the existing fill bits; fill = s.
  - s < OUT_WIDTH, last_in: load acc[top OUT_WIDTH] with data bits followed by zero padding into the output register; last_out=1; fill=0.
  - s == OUT_WIDTH: load the full block into the output register; last_out=last_in; fill=0.
  - s > OUT_WIDTH: load the top OUT_WIDTH bits into the output register with last_out=0. The low s-OUT_WIDTH bits of the word become the MSBs of acc; fill = s-OUT_WIDTH. If last_in is set, go to FLUSH.
- FLUSH:
  - ready_in=0.
  - When the output register is free or draining, load the residual zero-padded to OUT_WIDTH with last_out=1; fill=0; go to FILL.
- ready_in, combinational:
  - In FLUSH: 0.
  - In FILL: 1 when !(valid_out && !ready_out), or when fill+IN_WIDTH < OUT_WIDTH && !last_in.
- The output register is overwritten only when it is empty or is consumed in the same cycle.
- No word is ever dropped or duplicated.

## Timing
- Reset values: valid_out=0, last_out=0, data_out=0, fill=0, state=FILL, blk_cnt=0. ready_in=1 after reset.
- Latency: valid_out rises the cycle after the block-completing word is accepted. The FLUSH block appears at the earliest one cycle after the previous block is consumed.
- Sustained throughput: one word per cycle while ready_out=1. The FLUSH cycle costs one input bubble per frame when the residual is non-zero.
- data_out and last_out are held stable while valid_out && !ready_out.
- A simultaneous consume of the old block and load of a new block keeps valid_out=1 with no gap.
- Reset mid-frame discards acc, the residual, and any pending block. The next accepted word starts a fresh block at bit OUT_WIDTH-1.

## Configuration
- WORD_PACKER_STATS_EN defined:
  - blk_cnt increments on each valid_out && ready_out and wraps at 2^16.
  - Reset value 0.
- WORD_PACKER_STATS_EN undefined: the blk_cnt port and counter logic are absent.

## Structure
- Shared package ldpc_pkg holds:
  - LDPC_K_BITS=648
  - BUS_WIDTH=32
  - the state typedef enum logic {FILL, FLUSH} packer_state_t
- Single module; no sub-module is warranted. Shift and merge logic stays inline.

## Test plan
- Reset: hold rst=0 with random inputs. Required: valid_out=0, last_out=0, data_out=0, ready_in=1, blk_cnt=0.
- Stream: 81 back-to-back words 0..80 with ready_out=1, last_in=0.
  - Required: exactly 4 blocks, valid_out the cycle after words 20, 40, 60, 80.
  - Block0[647:616]=word0 and block0[7:0]=word20[31:24].
  - Block1[647:624]=word20[23:0].
  - fill=0 at the end.
- Backpressure: ready_out=0 from block0 onward.
  - Required: data_out stable and ready_in=0 when word 40 would complete block1; no loss.
  - After release, block1 follows block0 in order.
- Short frame: last_in on word 10 (352 bits).
  - Required: block[647:296]=words0..10, block[295:0]=0, last_out=1, fill=0.
- Overflow frame: last_in on word 20.
  - Required: full block with last_out=0, then one FLUSH cycle with ready_in=0.
  - Then a padded block with [647:624]=word20[23:0], the remaining bits 0, last_out=1.
- Mid-reset: assert rst after 15 words, release, then send 21 words.
  - Required: the first block starts with the new word0; no stale bits.

Source files
------------

// File: rtl/ldpc_pkg.sv
// Shared LDPC front-end constants and the word packer state type.
package ldpc_pkg;
  localparam int unsigned LDPC_K_BITS = 648;
  localparam int unsigned BUS_WIDTH   = 32;

  typedef enum logic {FILL, FLUSH} packer_state_t;
endpackage

// File: rtl/word_packer.sv
// Narrow-to-wide gearbox: packs IN_WIDTH words MSB-first into OUT_WIDTH blocks for the LDPC encoder.
// Define WORD_PACKER_STATS_EN to add the blk_cnt emitted-block counter.
module word_packer
  import ldpc_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = BUS_WIDTH,
  parameter int unsigned OUT_WIDTH = LDPC_K_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [IN_WIDTH-1:0]  data_in,
  input  logic                 last_in,
  output logic                 ready_in,
  output logic                 valid_out,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic                 last_out,
  input  logic                 ready_out
`ifdef WORD_PACKER_STATS_EN
  ,
  output logic [15:0]          blk_cnt
`endif
);

  localparam int unsigned ACC_W  = OUT_WIDTH + IN_WIDTH;
  localparam int unsigned FILL_W = $clog2(ACC_W + 1);

  packer_state_t     state;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  merged;
  logic [ACC_W-1:0]  carry;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] sum;
  logic              out_free;
  logic              accept;

  // acc is kept zero below fill, so OR-merging the shifted word appends it without masking.
  always_comb begin
    out_free = !valid_out || ready_out;
    sum      = fill + FILL_W'(IN_WIDTH);
    merged   = acc | ({data_in, {OUT_WIDTH{1'b0}}} >> fill);
    carry    = merged << OUT_WIDTH;
    ready_in = 1'b0;
    if (state == FILL) begin
      ready_in = out_free || ((sum < FILL_W'(OUT_WIDTH)) && !last_in);
    end
    accept   = valid_in && ready_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FILL;
      acc       <= '0;
      fill      <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      last_out  <= 1'b0;
    end else begin
      if (ready_out) begin
        valid_out <= 1'b0;
      end
      if (state == FILL) begin
        if (accept) begin
          if ((sum < FILL_W'(OUT_WIDTH)) && !last_in) begin
            acc  <= merged;
            fill <= sum;
          end else begin
            valid_out <= 1'b1;
            data_out  <= merged[ACC_W-1 -: OUT_WIDTH];
            if (sum > FILL_W'(OUT_WIDTH)) begin
              // Word straddles the block boundary: its tail seeds the next block.
              acc      <= carry;
              fill     <= sum - FILL_W'(OUT_WIDTH);
              last_out <= 1'b0;
              if (last_in) begin
                state <= FLUSH;
              end
            end else begin
              acc      <= '0;
              fill     <= '0;
              last_out <= last_in;
            end
          end
        end
      end else if (out_free) begin
        valid_out <= 1'b1;
        data_out  <= acc[ACC_W-1 -: OUT_WIDTH];
        last_out  <= 1'b1;
        acc       <= '0;
        fill      <= '0;
        state     <= FILL;
      end
    end
  end

`ifdef WORD_PACKER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk_cnt <= '0;
    end else if (valid_out && ready_out) begin
      blk_cnt <= blk_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_word_packer.sv
// Directed, table-driven bench for word_packer (IN_WIDTH=32, OUT_WIDTH=648).
module tb_word_packer;
  localparam int unsigned IW = 32;
  localparam int unsigned OW = 648;
  localparam int NF = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_in = 1'b0;
  logic          last_in = 1'b0;
  logic [IW-1:0] data_in = '0;
  logic          ready_in;
  logic          valid_out;
  logic [OW-1:0] data_out;
  logic          last_out;
  logic          ready_out = 1'b1;
`ifdef WORD_PACKER_STATS_EN
  logic [15:0]   blk_cnt;
`endif

  word_packer dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .last_in   (last_in),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .last_out  (last_out),
    .ready_out (ready_out)
`ifdef WORD_PACKER_STATS_EN
    ,
    .blk_cnt   (blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  logic [OW-1:0] q_data[$];
  bit            q_last[$];
  int            q_cyc[$];

  // Collect every consumed block with the cycle it was visible in.
  always @(negedge clk) begin
    #2;
    if (rst && valid_out && ready_out) begin
      q_data.push_back(data_out);
      q_last.push_back(last_out);
      q_cyc.push_back(cyc);
    end
  end

  typedef struct {
    int       n_words;
    bit       last;
    int       n_blocks;
    bit [3:0] last_mask;
    int       stall0;
  } frame_t;

  frame_t tbl[NF];
  int     acc_c[NF][81];

  function automatic void chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [IW-1:0] wd(input int salt, input int i);
    logic [7:0] a, b, c, e;
    a = 8'(i);
    b = ~a;
    c = 8'(i * 3 + salt);
    e = a ^ 8'h5a;
    return {a, b, c, e};
  endfunction

  // Reference block: frame bits [start, start+OW) with zero fill past total.
  function automatic logic [OW-1:0] make_block(input int salt, input int start, input int total);
    logic [OW-1:0] b;
    logic [IW-1:0] w;
    int idx;
    b = '0;
    for (int j = 0; j < int'(OW); j++) begin
      idx = start + j;
      if (idx < total) begin
        w = wd(salt, idx / 32);
        b[OW-1-j] = w[31 - (idx % 32)];
      end
    end
    return b;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic send_word(input logic [IW-1:0] d, input logic l, output int acc_cyc, output int stalls);
    stalls = 0;
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = d;
    last_in  = l;
    #1;
    while (!ready_in && stalls < 200) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (!ready_in) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: ready_in stuck at %0b, required 1", ready_in);
      acc_cyc = -1;
    end else begin
      acc_cyc = cyc + 1;
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic wait_blocks(input int n);
    for (int i = 0; i < 200 && q_data.size() < n; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int ac, st, p, total, endb, prevb, w, pw, expc, rest;
    logic [OW-1:0] b0, b1, b5, b6;
    logic [IW-1:0] wv;

    tbl[0] = '{81, 1'b0, 4, 4'b0000, 0};
    tbl[1] = '{11, 1'b1, 1, 4'b0001, 0};
    tbl[2] = '{21, 1'b1, 2, 4'b0010, 0};
    tbl[3] = '{81, 1'b1, 4, 4'b1000, 1};
    tbl[4] = '{20, 1'b1, 1, 4'b0001, 0};

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      valid_in  = 1'($urandom);
      last_in   = 1'($urandom);
      ready_out = 1'($urandom);
      data_in   = $urandom;
      #2;
      chk($sformatf("rst_valid_out%0d", i), OW'(valid_out), '0);
      chk($sformatf("rst_last_out%0d", i), OW'(last_out), '0);
      chk($sformatf("rst_data_out%0d", i), data_out, '0);
      chk($sformatf("rst_ready_in%0d", i), OW'(ready_in), OW'(1));
`ifdef WORD_PACKER_STATS_EN
      chk($sformatf("rst_blk_cnt%0d", i), OW'(blk_cnt), '0);
`endif
    end
    @(negedge clk);
    valid_in  = 1'b0;
    last_in   = 1'b0;
    ready_out = 1'b1;
    rst       = 1'b1;

    // Frame table, sent back to back
    rest = 0;
    for (int f = 0; f < NF; f++) begin
      for (int i = 0; i < tbl[f].n_words; i++) begin
        send_word(wd(f, i), tbl[f].last && (i == tbl[f].n_words - 1), ac, st);
        acc_c[f][i] = ac;
        if (i == 0) chk($sformatf("f%0d_first_stall", f), OW'(st), OW'(tbl[f].stall0));
        else rest += st;
      end
    end
    idle();
    wait_blocks(12);
    chk("tbl_stalls", OW'(rest), '0);
    chk("tbl_block_count", OW'(q_data.size()), OW'(12));

    p = 0;
    for (int f = 0; f < NF; f++) begin
      total = tbl[f].n_words * 32;
      for (int k = 0; k < tbl[f].n_blocks; k++) begin
        if (p < q_data.size()) begin
          endb  = imin((k + 1) * int'(OW), total);
          prevb = imin(k * int'(OW), total);
          w     = (endb + 31) / 32 - 1;
          pw    = (k == 0) ? -1 : (prevb + 31) / 32 - 1;
          expc  = acc_c[f][w] + ((w == pw) ? 1 : 0);
          chk($sformatf("f%0d_b%0d_data", f, k), q_data[p], make_block(f, k * int'(OW), total));
          chk($sformatf("f%0d_b%0d_last", f, k), OW'(q_last[p]), OW'(tbl[f].last_mask[k]));
          chk($sformatf("f%0d_b%0d_cycle", f, k), OW'(q_cyc[p]), OW'(expc));
          if (p == 0) b0 = q_data[p];
          if (p == 1) b1 = q_data[p];
          if (p == 5) b5 = q_data[p];
          if (p == 6) b6 = q_data[p];
        end
        p++;
      end
    end

    // Hand-computed bit positions
    wv = wd(0, 0);
    chk("stream_b0_msw", OW'(b0[647:616]), OW'(wv));
    wv = wd(0, 20);
    chk("stream_b0_lsb", OW'(b0[7:0]), OW'(wv[31:24]));
    chk("stream_b1_msb", OW'(b1[647:624]), OW'(wv[23:0]));
    wv = wd(2, 20);
    chk("ovf_full_tail", OW'(b5[7:0]), OW'(wv[31:24]));
    chk("ovf_pad_msb", OW'(b6[647:624]), OW'(wv[23:0]));
    chk("ovf_pad_zero", OW'(b6[623:0]), '0);
    chk("fill_end", OW'(dut.fill), '0);
`ifdef WORD_PACKER_STATS_EN
    chk("blk_cnt", OW'(blk_cnt), OW'(12));
`endif

    // Backpressure: block0 held while word 40 waits
    q_data.delete(); q_last.delete(); q_cyc.delete();
    @(negedge clk);
    ready_out = 1'b0;
    rest = 0;
    for (int i = 0; i < 40; i++) begin
      send_word(wd(5, i), 1'b0, ac, st);
      rest += st;
    end
    chk("bp_early_stalls", OW'(rest), '0);
    fork
      send_word(wd(5, 40), 1'b0, ac, st);
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          #2;
          chk($sformatf("bp_ready_in%0d", i), OW'(ready_in), '0);
          chk($sformatf("bp_valid%0d", i), OW'(valid_out), OW'(1));
          chk($sformatf("bp_hold%0d", i), data_out, make_block(5, 0, 1312));
        end
        @(negedge clk);
        ready_out = 1'b1;
      end
    join
    idle();
    wait_blocks(2);
    chk("bp_count", OW'(q_data.size()), OW'(2));
    if (q_data.size() >= 2) begin
      chk("bp_b0", q_data[0], make_block(5, 0, 1312));
      chk("bp_b1", q_data[1], make_block(5, 648, 1312));
      chk("bp_no_gap", OW'(q_cyc[1]), OW'(q_cyc[0] + 1));
      chk("bp_last", OW'({q_last[0], q_last[1]}), '0);
    end

    // Reset mid-frame, then a fresh frame
    q_data.delete(); q_last.delete(); q_cyc.delete();
    for (int i = 0; i < 15; i++) send_word(wd(7, i), 1'b0, ac, st);
    idle();
    @(negedge clk);
    rst      = 1'b0;
    valid_in = 1'b1;
    data_in  = $urandom;
    #2;
    chk("midrst_valid", OW'(valid_out), '0);
    chk("midrst_fill", OW'(dut.fill), '0);
    @(negedge clk);
    valid_in = 1'b0;
    rst      = 1'b1;
    for (int i = 0; i < 21; i++) send_word(wd(9, i), 1'b0, ac, st);
    idle();
    wait_blocks(1);
    chk("midrst_count", OW'(q_data.size()), OW'(1));
    if (q_data.size() >= 1) begin
      chk("midrst_b0", q_data[0], make_block(9, 0, 672));
      chk("midrst_last", OW'(q_last[0]), '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
